// File: rtl/input_buffer_feeder_if.sv
// rtl/input_buffer_feeder_if.sv - SRAM read port and MUX_REG buffer port of the input feeder
interface input_buffer_feeder_if #(
    parameter int ADDR_W = 10
) ();
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic [31:0]       buffer;
    logic              buffer_valid;
    logic              mux_sync;

    modport master (
        output mem_en,
        output mem_addr,
        input  mem_rdata,
        output buffer,
        output buffer_valid,
        output mux_sync
    );

    modport slave (
        input  mem_en,
        input  mem_addr,
        output mem_rdata,
        input  buffer,
        input  buffer_valid,
        input  mux_sync
    );
endinterface

// File: rtl/input_buffer_feeder.sv
// rtl/input_buffer_feeder.sv - streams SRAM words into Input_MUX_REG, holding each for 1/2/4 cycles
module input_buffer_feeder #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              weight_bitwidth,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [CNT_W-1:0]        num_words,
    input_buffer_feeder_if.master   bus,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_ALIGN,
        S_STREAM,
        S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        hold_m1;    // hold factor minus one, latched at start
    logic [1:0]        phase;
    logic [1:0]        gap;        // cycles elapsed since the most recent read
    logic [CNT_W-1:0]  rd_left;
    logic [CNT_W-1:0]  wr_left;
    logic [ADDR_W-1:0] next_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            hold_m1          <= 2'd0;
            phase            <= 2'd0;
            gap              <= 2'd0;
            rd_left          <= '0;
            wr_left          <= '0;
            next_addr        <= '0;
            bus.mem_en       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.buffer       <= '0;
            bus.buffer_valid <= 1'b0;
            bus.mux_sync     <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            // A read lands two cycles before its word is presented, i.e. one per hold period.
            if (state == S_PRIME || state == S_ALIGN || state == S_STREAM) begin
                if (rd_left != '0 && gap == hold_m1) begin
                    bus.mem_en   <= 1'b1;
                    bus.mem_addr <= next_addr;
                    next_addr    <= next_addr + ADDR_W'(1);
                    rd_left      <= rd_left - CNT_W'(1);
                    gap          <= 2'd0;
                end else begin
                    bus.mem_en <= 1'b0;
                    gap        <= (gap == 2'd3) ? gap : gap + 2'd1;
                end
            end else begin
                bus.mem_en <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        case (weight_bitwidth)
                            2'b00:   hold_m1 <= 2'd0;
                            2'b01:   hold_m1 <= 2'd1;
                            default: hold_m1 <= 2'd3;
                        endcase
                        next_addr <= base_addr + ADDR_W'(1);
                        rd_left   <= num_words - CNT_W'(1);
                        wr_left   <= num_words - CNT_W'(1);
                        gap       <= 2'd0;
                        if (num_words != '0) begin
                            state        <= S_PRIME;
                            busy         <= 1'b1;
                            bus.mem_en   <= 1'b1;
                            bus.mem_addr <= base_addr;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_PRIME: begin
                    bus.mux_sync <= 1'b1;
                    state        <= S_ALIGN;
                end
                S_ALIGN: begin
                    bus.mux_sync     <= 1'b0;
                    bus.buffer       <= bus.mem_rdata;
                    bus.buffer_valid <= 1'b1;
                    phase            <= 2'd0;
                    state            <= S_STREAM;
                end
                S_STREAM: begin
                    if (phase == hold_m1) begin
                        if (wr_left == '0) begin
                            bus.buffer_valid <= 1'b0;
                            busy             <= 1'b0;
                            done             <= 1'b1;
                            state            <= S_DONE;
                        end else begin
                            bus.buffer <= bus.mem_rdata;
                            wr_left    <= wr_left - CNT_W'(1);
                            phase      <= 2'd0;
                        end
                    end else begin
                        phase <= phase + 2'd1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/input_buffer_feeder.md
# input_buffer_feeder

Streams 32-bit activation words from the input SRAM buffer into `Input_MUX_REG`. The feeder is the writer side of that block's `buffer` port. It holds each word for exactly as many cycles as the MUX_REG needs to consume it: 1 cycle for 8-bit weights, 2 for 4-bit, 4 for 2-bit. It pipelines SRAM reads so consecutive words arrive without bubbles. It also emits a sync pulse that realigns the MUX_REG's internal phase counter before the first word.

## Interface
Parameters:
- `ADDR_W`, 10, SRAM word-address width.
- `CNT_W`, 10, width of the word-count input.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `weight_bitwidth`  in  2  uses the same encoding as MUX_REG.
  - 00: 8-bit.
  - 01: 4-bit.
  - 10 or 11: 2-bit.
- `start`  in  1  one-cycle request to begin a run; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first SRAM word address; sampled with `start`.
- `num_words`  in  CNT_W  number of words to stream; sampled with `start`.
- `mem_en`  out  1  SRAM read enable, registered.
- `mem_addr`  out  ADDR_W  SRAM read address, registered.
- `mem_rdata`  in  32  SRAM read data, valid in the cycle after a cycle with `mem_en`=1.
- `buffer`  out  32  word presented to MUX_REG `buffer`.
- `buffer_valid`  out  1  high while `buffer` holds a live word.
- `mux_sync`  out  1  one-cycle pulse; drives (ORed into) the MUX_REG `reset`.
- `busy`  out  1  high from the cycle after `start` until the last word's final cycle.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Hold factor N is derived from `weight_bitwidth`, which is latched at `start`: 00 gives N=1, 01 gives N=2, 1x gives N=4.
  - Changes to `weight_bitwidth` mid-run are ignored.
- States and transitions:
  - IDLE: if `start` and `num_words`≠0, go to PRIME. If `start` and `num_words`=0, go to DONE. Otherwise stay in IDLE.
  - PRIME: one cycle. Drives `mem_en`=1 with `mem_addr`=`base_addr`. Go to ALIGN.
  - ALIGN: one cycle. Drives `mux_sync`=1. Issues the second read if needed (see the read rule). Go to STREAM.
  - STREAM: `buffer` loads `mem_rdata` at each word boundary, and `buffer_valid`=1. A phase counter counts 0..N-1 per word. After the final phase of the last word, go to DONE.
  - DONE: one cycle with `done`=1, `busy`=0. Go to IDLE.
- Read rule: the read for word i is issued exactly 2 cycles before word i is first presented.
  - Total reads equal `num_words` exactly; there is no over-fetch.
  - For N=1, reads issue every cycle.
- Address arithmetic: the address increments by 1 per read and wraps modulo 2^ADDR_W.
- A `start` that arrives while not in IDLE is ignored.
- `buffer` keeps its last word after the run ends; `buffer_valid` drops to 0.
- `reset` mid-run returns the block to IDLE on the next edge and drives all outputs to 0. Reads still in flight are discarded.

## Timing
- Reset values: `buffer`=0, `buffer_valid`=0, `mem_en`=0, `mem_addr`=0, `mux_sync`=0, `busy`=0, `done`=0. State is IDLE.
- Cycle numbering: cycle 0 is the cycle in which `start` is high.
- First read: `mem_en` is high in cycle 1.
- Sync: `mux_sync` is high in cycle 2.
- First word: `buffer_valid` rises in cycle 3, and word 0 is on `buffer` in cycle 3.
- Word k occupies cycles 3+kN through 3+kN+N-1.
- `done` is high in cycle 3+N·`num_words`.
- `busy` is high in cycles 1 through 2+N·`num_words`.
- `num_words`=0: `done` is high in cycle 1, with no reads and no `mux_sync`.
- Because `mux_sync` fires in cycle 2, the MUX_REG phase is 0 in cycle 3. MUX_REG phase and feeder phase then stay equal on every cycle.

## Test plan
- bw=00, `base_addr`=5, `num_words`=3, SRAM[a]=a·0x01010101 -> reads in cycles 1,2,3 to addresses 5,6,7. `buffer` = 0x05050505, 0x06060606, 0x07070707 in cycles 3,4,5. `done` in cycle 6.
- bw=01, `num_words`=2, base=0 -> reads in cycles 1 and 3. Word 0 on `buffer` in cycles 3–4, word 1 in cycles 5–6. `done` in cycle 7. `mux_sync` only in cycle 2.
- bw=10, `num_words`=2 -> reads in cycles 1 and 5. Each word is held 4 cycles (cycles 3–10). `done` in cycle 11. The connected MUX_REG `sorted_data` matches the 4× replication of each 2-bit slice.
- base=0x3FF, `num_words`=2, bw=00 -> addresses 0x3FF then 0x000. A `start` pulsed in cycle 2 is ignored.
- `num_words`=0 -> `done` in cycle 1. `mem_en`, `buffer_valid` and `mux_sync` never assert.
- `reset` asserted in cycle 4 of the bw=10 run -> in cycle 5 all outputs are 0 and the state is IDLE. A fresh `start` in cycle 6 reproduces the full run timing from its own cycle 0.
